// File: rtl/axi2fta_rd_resp32_pkg.sv
// Shared types for the AXI R-channel to FTA response converter:
// table entry layout, FTA error codes, AXI rresp codes.
package axi2fta_rd_resp32_pkg;

   localparam int FTA_TID_W = 13;
   localparam int FTA_ADR_W = 32;

   typedef enum logic [1:0] {
      FTA_OKAY   = 2'd0,
      FTA_ERR    = 2'd1,
      FTA_DECERR = 2'd2
   } fta_err_e;

   typedef enum logic [1:0] {
      AXI_OKAY   = 2'd0,
      AXI_EXOKAY = 2'd1,
      AXI_SLVERR = 2'd2,
      AXI_DECERR = 2'd3
   } axi_rresp_e;

   typedef struct packed {
      logic                 valid;
      logic [FTA_TID_W-1:0] tid;
      logic [FTA_ADR_W-1:0] adr;
      logic [3:0]           pri;
      logic [7:0]           beat;
   } rd_track_entry_t;

   function automatic fta_err_e map_rresp(logic [1:0] r);
      fta_err_e e;
      e = FTA_OKAY;
      unique case (r)
         AXI_SLVERR: e = FTA_ERR;
         AXI_DECERR: e = FTA_DECERR;
         default:    e = FTA_OKAY;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/axi2fta_rd_resp32_if.sv
// Bus bundle: AR issue tracking, AXI R channel, FTA response.
// slave = converter view, master = issuer/memory/consumer view.
interface axi2fta_rd_resp32_if #(
   parameter int DATA_W = 32,
   parameter int ADR_W  = 32,
   parameter int TID_W  = 13
);
   logic              ar_issue_i;
   logic [TID_W-1:0]  ar_tid_i;
   logic [ADR_W-1:0]  ar_adr_i;
   logic [3:0]        ar_pri_i;
   logic              ar_full_o;
   logic              rvalid_i;
   logic              rready_o;
   logic [TID_W-1:0]  rid_i;
   logic [DATA_W-1:0] rdata_i;
   logic [1:0]        rresp_i;
   logic              rlast_i;
   logic              resp_ack_o;
   logic [TID_W-1:0]  resp_tid_o;
   logic [ADR_W-1:0]  resp_adr_o;
   logic [3:0]        resp_pri_o;
   logic [DATA_W-1:0] resp_dat_o;
   logic [1:0]        resp_err_o;
   logic              resp_stall_i;
   logic              orphan_o;
   logic              dup_err_o;

   modport slave (
      input  ar_issue_i, ar_tid_i, ar_adr_i, ar_pri_i,
      output ar_full_o,
      input  rvalid_i, rid_i, rdata_i, rresp_i, rlast_i,
      output rready_o,
      output resp_ack_o, resp_tid_o, resp_adr_o,
      output resp_pri_o, resp_dat_o, resp_err_o,
      input  resp_stall_i,
      output orphan_o, dup_err_o
   );

   modport master (
      output ar_issue_i, ar_tid_i, ar_adr_i, ar_pri_i,
      input  ar_full_o,
      output rvalid_i, rid_i, rdata_i, rresp_i, rlast_i,
      input  rready_o,
      input  resp_ack_o, resp_tid_o, resp_adr_o,
      input  resp_pri_o, resp_dat_o, resp_err_o,
      output resp_stall_i,
      input  orphan_o, dup_err_o
   );
endinterface

// File: rtl/axi2fta_rd_resp32_cam.sv
// axi_rid_cam: combinational tid CAM over the outstanding table.
// Ports: vld_i/tid_i table view; rid/ar lookups; lowest free; full.
module axi_rid_cam #(
   parameter int TID_W = 13,
   parameter int NOUT  = 8,
   parameter int IDX_W = $clog2(NOUT)
) (
   input  logic [NOUT-1:0]  vld_i,
   input  logic [TID_W-1:0] tid_i [NOUT],
   input  logic [TID_W-1:0] rid_i,
   input  logic [TID_W-1:0] ar_tid_i,
   output logic             rid_hit_o,
   output logic [NOUT-1:0]  rid_oh_o,
   output logic [IDX_W-1:0] rid_idx_o,
   output logic             ar_hit_o,
   output logic [IDX_W-1:0] free_idx_o,
   output logic             full_o
);
   logic [NOUT-1:0] ar_oh;

   always_comb begin
      rid_oh_o   = '0;
      ar_oh      = '0;
      rid_idx_o  = '0;
      free_idx_o = '0;
      for (int i = 0; i < NOUT; i++) begin
         rid_oh_o[i] = vld_i[i] & (tid_i[i] == rid_i);
         ar_oh[i]    = vld_i[i] & (tid_i[i] == ar_tid_i);
         if (rid_oh_o[i])
            rid_idx_o = IDX_W'(i);
      end
      // descending scan leaves the lowest free index
      for (int i = NOUT - 1; i >= 0; i--) begin
         if (!vld_i[i])
            free_idx_o = IDX_W'(i);
      end
      rid_hit_o = |rid_oh_o;
      ar_hit_o  = |ar_oh;
   end

   assign full_o = &vld_i;

endmodule

// File: rtl/axi2fta_rd_resp32.sv
// Tracks outstanding AXI reads and turns R beats into FTA responses.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module axi2fta_rd_resp32
   import axi2fta_rd_resp32_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADR_W  = FTA_ADR_W,
   parameter int TID_W  = FTA_TID_W,
   parameter int NOUT   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   axi2fta_rd_resp32_if.slave   bus
);
   localparam int IDX_W = $clog2(NOUT);
   localparam int BLG   = $clog2(DATA_W / 8);

   rd_track_entry_t ent_q [NOUT];
   rd_track_entry_t ent_d [NOUT];

   logic [NOUT-1:0]  vld;
   logic [TID_W-1:0] tids [NOUT];
   logic             rid_hit;
   logic [NOUT-1:0]  rid_oh;
   logic [IDX_W-1:0] rid_idx;
   logic             ar_hit;
   logic [IDX_W-1:0] free_idx;
   logic             full;

   logic              resp_ack_q, resp_ack_d;
   logic [TID_W-1:0]  resp_tid_q, resp_tid_d;
   logic [ADR_W-1:0]  resp_adr_q, resp_adr_d;
   logic [3:0]        resp_pri_q, resp_pri_d;
   logic [DATA_W-1:0] resp_dat_q, resp_dat_d;
   logic [1:0]        resp_err_q, resp_err_d;
   logic              orphan_q, orphan_d;
   logic              dup_err_q, dup_err_d;

   logic             rready;
   logic             acc;
   logic             hold;
   logic             alloc;
   logic [ADR_W-1:0] hit_adr;
   logic [ADR_W-1:0] hit_off;

   always_comb begin
      for (int i = 0; i < NOUT; i++) begin
         vld[i]  = ent_q[i].valid;
         tids[i] = TID_W'(ent_q[i].tid);
      end
   end

   axi_rid_cam #(
      .TID_W (TID_W),
      .NOUT  (NOUT)
   ) u_cam (
      .vld_i      (vld),
      .tid_i      (tids),
      .rid_i      (bus.rid_i),
      .ar_tid_i   (bus.ar_tid_i),
      .rid_hit_o  (rid_hit),
      .rid_oh_o   (rid_oh),
      .rid_idx_o  (rid_idx),
      .ar_hit_o   (ar_hit),
      .free_idx_o (free_idx),
      .full_o     (full)
   );

   always_comb begin
      rready = ~rst & (~resp_ack_q | ~bus.resp_stall_i);
      acc    = bus.rvalid_i & rready;
      hold   = resp_ack_q & bus.resp_stall_i;
      alloc  = bus.ar_issue_i & ~full & ~ar_hit;

      hit_adr = ADR_W'(ent_q[rid_idx].adr);
      hit_off = ADR_W'(ent_q[rid_idx].beat) << BLG;

      ent_d = ent_q;
      if (alloc) begin
         ent_d[free_idx].valid = 1'b1;
         ent_d[free_idx].tid   = FTA_TID_W'(bus.ar_tid_i);
         ent_d[free_idx].adr   = FTA_ADR_W'(bus.ar_adr_i);
         ent_d[free_idx].pri   = bus.ar_pri_i;
         ent_d[free_idx].beat  = 8'd0;
      end
      // alloc targets a free slot, a hit is a live one: no overlap
      for (int i = 0; i < NOUT; i++) begin
         if (acc & rid_oh[i]) begin
            ent_d[i].beat = ent_q[i].beat + 8'd1;
            if (bus.rlast_i)
               ent_d[i].valid = 1'b0;
         end
      end

      resp_ack_d = 1'b0;
      resp_tid_d = resp_tid_q;
      resp_adr_d = resp_adr_q;
      resp_pri_d = resp_pri_q;
      resp_dat_d = resp_dat_q;
      resp_err_d = resp_err_q;
      orphan_d   = 1'b0;
      dup_err_d  = bus.ar_issue_i & ar_hit;

      if (hold) begin
         resp_ack_d = 1'b1;
      end else if (acc) begin
         resp_ack_d = 1'b1;
         resp_tid_d = bus.rid_i;
         resp_dat_d = bus.rdata_i;
         if (rid_hit) begin
            resp_adr_d = hit_adr + hit_off;
            resp_pri_d = ent_q[rid_idx].pri;
            resp_err_d = map_rresp(bus.rresp_i);
         end else begin
            resp_adr_d = '0;
            resp_pri_d = '0;
            resp_err_d = FTA_DECERR;
            orphan_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NOUT; i++)
            ent_q[i] <= '0;
         resp_ack_q <= 1'b0;
         resp_tid_q <= '0;
         resp_adr_q <= '0;
         resp_pri_q <= '0;
         resp_dat_q <= '0;
         resp_err_q <= '0;
         orphan_q   <= 1'b0;
         dup_err_q  <= 1'b0;
      end else begin
         ent_q      <= ent_d;
         resp_ack_q <= resp_ack_d;
         resp_tid_q <= resp_tid_d;
         resp_adr_q <= resp_adr_d;
         resp_pri_q <= resp_pri_d;
         resp_dat_q <= resp_dat_d;
         resp_err_q <= resp_err_d;
         orphan_q   <= orphan_d;
         dup_err_q  <= dup_err_d;
      end
   end

   assign bus.ar_full_o  = full;
   assign bus.rready_o   = rready;
   assign bus.resp_ack_o = resp_ack_q;
   assign bus.resp_tid_o = resp_tid_q;
   assign bus.resp_adr_o = resp_adr_q;
   assign bus.resp_pri_o = resp_pri_q;
   assign bus.resp_dat_o = resp_dat_q;
   assign bus.resp_err_o = resp_err_q;
   assign bus.orphan_o   = orphan_q;
   assign bus.dup_err_o  = dup_err_q;

endmodule

// File: tb/tb_axi2fta_rd_resp32.sv
// Bench for axi2fta_rd_resp32: per-cycle vector table plus
// hand sequences for stall, reset mid-burst and beat wrap.
module tb_axi2fta_rd_resp32;

   localparam logic [1:0] E_OK  = 2'd0;
   localparam logic [1:0] E_ERR = 2'd1;
   localparam logic [1:0] E_DEC = 2'd2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi2fta_rd_resp32_if bus ();

   axi2fta_rd_resp32 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        iss;
      logic [12:0] atid;
      logic [31:0] aadr;
      logic [3:0]  apri;
      logic        rv;
      logic [12:0] rid;
      logic [31:0] dat;
      logic [1:0]  rr;
      logic        last;
      logic        e_full;
      logic        e_ack;
      logic [31:0] e_adr;
      logic [3:0]  e_pri;
      logic [1:0]  e_err;
      logic        e_orph;
      logic        e_dup;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t vn(logic f);
      vec_t v;
      v = '{default: '0};
      v.e_full = f;
      return v;
   endfunction

   function automatic vec_t vi(logic [12:0] t, logic [31:0] a,
                               logic [3:0] p, logic f, logic d);
      vec_t v;
      v = vn(f);
      v.iss   = 1'b1;
      v.atid  = t;
      v.aadr  = a;
      v.apri  = p;
      v.e_dup = d;
      return v;
   endfunction

   function automatic vec_t vb(logic [12:0] r, logic [31:0] d,
                               logic [1:0] rr, logic l, logic f,
                               logic [31:0] ea, logic [3:0] ep,
                               logic [1:0] ee, logic eo);
      vec_t v;
      v = vn(f);
      v.rv     = 1'b1;
      v.rid    = r;
      v.dat    = d;
      v.rr     = rr;
      v.last   = l;
      v.e_ack  = 1'b1;
      v.e_adr  = ea;
      v.e_pri  = ep;
      v.e_err  = ee;
      v.e_orph = eo;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.ar_issue_i   = v.iss;
      bus.ar_tid_i     = v.atid;
      bus.ar_adr_i     = v.aadr;
      bus.ar_pri_i     = v.apri;
      bus.rvalid_i     = v.rv;
      bus.rid_i        = v.rid;
      bus.rdata_i      = v.dat;
      bus.rresp_i      = v.rr;
      bus.rlast_i      = v.last;
      bus.resp_stall_i = 1'b0;
   endtask

   task automatic beat(logic [12:0] r, logic [31:0] d, logic l);
      bus.ar_issue_i = 1'b0;
      bus.rvalid_i   = 1'b1;
      bus.rid_i      = r;
      bus.rdata_i    = d;
      bus.rresp_i    = 2'd0;
      bus.rlast_i    = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      drive(vn(1'b0));
      rst = 1'b1;

      tick();
      chk("rst rready", bus.rready_o, 1'b0);
      tick();
      chk("rst ack", bus.resp_ack_o, 1'b0);
      chk("rst full", bus.ar_full_o, 1'b0);
      chk("rst orphan", bus.orphan_o, 1'b0);
      chk("rst dup", bus.dup_err_o, 1'b0);
      chk("rst adr", bus.resp_adr_o, 32'h0);
      chk("rst tid", bus.resp_tid_o, 13'h0);
      chk("rst err", bus.resp_err_o, 2'd0);
      rst = 1'b0;
      #1;
      chk("post-rst rready", bus.rready_o, 1'b1);

      // basic 4-beat burst, error mapping, freed entry
      tbl.push_back(vi(5, 32'h1000, 3, 0, 0));
      tbl.push_back(vb(5, 32'hA0, 0, 0, 0, 32'h1000, 3, E_OK, 0));
      tbl.push_back(vb(5, 32'hA1, 0, 0, 0, 32'h1004, 3, E_OK, 0));
      tbl.push_back(vb(5, 32'hA2, 2, 0, 0, 32'h1008, 3, E_ERR, 0));
      tbl.push_back(vb(5, 32'hA3, 1, 1, 0, 32'h100C, 3, E_OK, 0));
      tbl.push_back(vb(5, 32'hA4, 0, 1, 0, 32'h0, 0, E_DEC, 1));
      tbl.push_back(vn(0));
      // fill table, overflow issue, free one
      for (int i = 0; i < 8; i++)
         tbl.push_back(vi(13'(i), 32'h2000 + 32'(i) * 32'h100,
                          4'(i), 0, 0));
      tbl.push_back(vi(8, 32'h8000, 8, 1, 0));
      tbl.push_back(vn(1));
      tbl.push_back(vb(3, 32'hB3, 0, 1, 1, 32'h2300, 3, E_OK, 0));
      tbl.push_back(vn(0));
      tbl.push_back(vb(8, 32'hB8, 0, 0, 0, 32'h0, 0, E_DEC, 1));
      // interleaved rid 2 / 7
      tbl.push_back(vb(2, 32'hC0, 0, 0, 0, 32'h2200, 2, E_OK, 0));
      tbl.push_back(vb(7, 32'hC1, 0, 0, 0, 32'h2700, 7, E_OK, 0));
      tbl.push_back(vb(7, 32'hC2, 0, 0, 0, 32'h2704, 7, E_OK, 0));
      tbl.push_back(vb(2, 32'hC3, 0, 0, 0, 32'h2204, 2, E_OK, 0));
      tbl.push_back(vb(2, 32'hC4, 0, 1, 0, 32'h2208, 2, E_OK, 0));
      tbl.push_back(vb(7, 32'hC5, 3, 1, 0, 32'h2708, 7, E_DEC, 0));
      // orphan, duplicate, reuse, address wrap
      tbl.push_back(vb(13'h1FF, 32'hD0, 0, 0, 0, 32'h0, 0, E_DEC, 1));
      tbl.push_back(vi(1, 32'h9990, 4'hE, 0, 1));
      tbl.push_back(vb(1, 32'hE1, 0, 0, 0, 32'h2100, 1, E_OK, 0));
      tbl.push_back(vi(13'h10, 32'h3000, 9, 0, 0));
      tbl.push_back(vb(13'h10, 32'hE2, 0, 0, 0, 32'h3000, 9, E_OK, 0));
      tbl.push_back(vi(13'h20, 32'hFFFF_FFFC, 4'hF, 0, 0));
      tbl.push_back(vb(13'h20, 32'hE3, 0, 0, 0, 32'hFFFF_FFFC, 4'hF,
                       E_OK, 0));
      tbl.push_back(vb(13'h20, 32'hE4, 0, 1, 0, 32'h0, 4'hF, E_OK, 0));
      tbl.push_back(vn(0));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v);
         #1;
         chk($sformatf("v%0d full", i), bus.ar_full_o, v.e_full);
         chk($sformatf("v%0d rready", i), bus.rready_o, 1'b1);
         tick();
         chk($sformatf("v%0d ack", i), bus.resp_ack_o, v.e_ack);
         chk($sformatf("v%0d orphan", i), bus.orphan_o, v.e_orph);
         chk($sformatf("v%0d dup", i), bus.dup_err_o, v.e_dup);
         if (v.e_ack) begin
            chk($sformatf("v%0d tid", i), bus.resp_tid_o, v.rid);
            chk($sformatf("v%0d adr", i), bus.resp_adr_o, v.e_adr);
            chk($sformatf("v%0d pri", i), bus.resp_pri_o, v.e_pri);
            chk($sformatf("v%0d dat", i), bus.resp_dat_o, v.dat);
            chk($sformatf("v%0d err", i), bus.resp_err_o, v.e_err);
         end
      end

      // stall: tid 0 live at 0x2000, beat 0
      beat(0, 32'h55, 0);
      #1;
      chk("stl rready0", bus.rready_o, 1'b1);
      tick();
      chk("stl ack0", bus.resp_ack_o, 1'b1);
      chk("stl dat0", bus.resp_dat_o, 32'h55);
      bus.rdata_i      = 32'h66;
      bus.resp_stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stl%0d rready", k), bus.rready_o, 1'b0);
         tick();
         chk($sformatf("stl%0d ack", k), bus.resp_ack_o, 1'b1);
         chk($sformatf("stl%0d dat", k), bus.resp_dat_o, 32'h55);
         chk($sformatf("stl%0d adr", k), bus.resp_adr_o, 32'h2000);
      end
      bus.resp_stall_i = 1'b0;
      #1;
      chk("stl rready1", bus.rready_o, 1'b1);
      tick();
      chk("stl ack1", bus.resp_ack_o, 1'b1);
      chk("stl dat1", bus.resp_dat_o, 32'h66);
      chk("stl adr1", bus.resp_adr_o, 32'h2004);
      bus.rdata_i = 32'h77;
      tick();
      chk("stl adr2", bus.resp_adr_o, 32'h2008);
      chk("stl dat2", bus.resp_dat_o, 32'h77);
      bus.rvalid_i = 1'b0;
      tick();
      chk("stl ack idle", bus.resp_ack_o, 1'b0);

      // reset mid-burst on tid 4
      beat(4, 32'h44, 0);
      tick();
      chk("rmb ack", bus.resp_ack_o, 1'b1);
      chk("rmb adr", bus.resp_adr_o, 32'h2400);
      bus.rvalid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("rmb rready", bus.rready_o, 1'b0);
      tick();
      chk("rmb ack drop", bus.resp_ack_o, 1'b0);
      chk("rmb full", bus.ar_full_o, 1'b0);
      rst = 1'b0;
      beat(4, 32'h45, 0);
      tick();
      chk("rmb orphan", bus.orphan_o, 1'b1);
      chk("rmb err", bus.resp_err_o, E_DEC);
      chk("rmb adr0", bus.resp_adr_o, 32'h0);

      // beat counter wraps at 256 without rlast
      bus.rvalid_i   = 1'b0;
      bus.ar_issue_i = 1'b1;
      bus.ar_tid_i   = 13'h30;
      bus.ar_adr_i   = 32'h4000;
      bus.ar_pri_i   = 4'h2;
      tick();
      for (int k = 0; k <= 256; k++) begin
         beat(13'h30, 32'(k), 0);
         tick();
         chk($sformatf("wrap%0d adr", k), bus.resp_adr_o,
             32'h4000 + 32'(k % 256) * 32'd4);
      end
      bus.rvalid_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
